// File: rtl/vga_timing_pkg.sv
// Shared types and helpers for the VGA timing generator.
//   vga_mode_t   : porch/sync/polarity set for one video mode
//   vga_flags_t  : decoded per-pixel flags carried through the delay line
//   calc_total() : active + front porch + sync + back porch
//   calc_cw()    : smallest counter width able to count 0..total-1
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0};

  localparam vga_mode_t MODE_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol: 1'b1, v_pol: 1'b1};

  localparam vga_mode_t MODE_1024X768_60 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    h_pol: 1'b0, v_pol: 1'b0};

  // Flags decoded from the counters; sync fields hold output levels.
  typedef struct packed {
    logic video_on;
    logic h_sync;
    logic v_sync;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control and timing bundle of the VGA timing generator.
//   master : generator side (reads pix_en/run, drives counters and decoded outputs)
//   slave  : consumer side (drives pix_en/run, reads everything else)
interface vga_timing_gen_if #(
  parameter int unsigned CW   = 11,
  parameter int unsigned FC_W = 8
);
  logic            pix_en;
  logic            run;
  logic [CW-1:0]   h_count;
  logic [CW-1:0]   v_count;
  logic [CW-1:0]   px_x;
  logic [CW-1:0]   px_y;
  logic            video_on;
  logic            h_sync;
  logic            v_sync;
  logic            line_start;
  logic            frame_start;
  logic [FC_W-1:0] frame_cnt;

  modport master (
    input  pix_en, run,
    output h_count, v_count, px_x, px_y, video_on, h_sync, v_sync,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    output pix_en, run,
    input  h_count, v_count, px_x, px_y, video_on, h_sync, v_sync,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on en, wraps to 0.
//   vga_clk, rst_n : clock, async active-low reset
//   en             : advance one position
//   clr            : force count to 0 (wins over en, suppresses wrap)
//   count          : current position (registered)
//   wrap           : high while the advancing tick takes count from TOTAL-1 to 0
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned CW    = 11
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] r_count;

  assign wrap  = en && !clr && (r_count == CW'(TOTAL - 1));
  assign count = r_count;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator.
//   vga_clk, rst_n : pixel/system clock, async active-low reset
//   bus (master)   : pix_en/run in; raw counters, aligned px_x/px_y, video_on,
//                    h_sync/v_sync, line_start/frame_start, frame_cnt out
// Decoded outputs lag the raw counters by 1+PIPE_DLY pix_en ticks.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CW       = 11,
  parameter int unsigned PIPE_DLY = 0,
  parameter int unsigned FC_W     = 8
) (
  input logic               vga_clk,
  input logic               rst_n,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int          DLY     = int'(PIPE_DLY);

  // Window bounds one bit wider so an end equal to 2^CW stays representable.
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_flags_t IDLE_FLAGS = '{video_on: 1'b0, h_sync: ~H_POL, v_sync: ~V_POL,
                                        line_start: 1'b0, frame_start: 1'b0};

  logic          w_run_tick;
  logic          w_clr;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [CW-1:0] w_h_count;
  logic [CW-1:0] w_v_count;
  logic [CW:0]   w_h_ext;
  logic [CW:0]   w_v_ext;
  vga_flags_t    w_s1_flags;
  logic [CW-1:0] w_s1_x;
  logic [CW-1:0] w_s1_y;

  vga_flags_t      r_flags [0:DLY];
  logic [CW-1:0]   r_px_x  [0:DLY];
  logic [CW-1:0]   r_px_y  [0:DLY];
  logic [FC_W-1:0] r_frame_cnt;

  // run is only acted on when a pix_en tick arrives.
  assign w_run_tick = bus.pix_en & bus.run;
  assign w_clr      = bus.pix_en & ~bus.run;

  vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_cnt (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (w_run_tick),
    .clr     (w_clr),
    .count   (w_h_count),
    .wrap    (w_h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_cnt (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (w_h_wrap),
    .clr     (w_clr),
    .count   (w_v_count),
    .wrap    (w_v_wrap)
  );

  assign w_h_ext = {1'b0, w_h_count};
  assign w_v_ext = {1'b0, w_v_count};

  // Stage-1 decode; idle values while stopped.
  always_comb begin
    w_s1_flags = IDLE_FLAGS;
    w_s1_x     = '0;
    w_s1_y     = '0;
    if (bus.run) begin
      w_s1_flags.video_on    = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
      w_s1_flags.h_sync      = ((w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END)) ? H_POL : ~H_POL;
      w_s1_flags.v_sync      = ((w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END)) ? V_POL : ~V_POL;
      w_s1_flags.line_start  = (w_h_count == '0);
      w_s1_flags.frame_start = (w_h_count == '0) && (w_v_count == '0);
      w_s1_x                 = w_h_count;
      w_s1_y                 = w_v_count;
    end
  end

  // Stage 1 plus PIPE_DLY shift stages; shifts on every tick, running or not.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DLY; i++) begin
        r_flags[i] <= IDLE_FLAGS;
        r_px_x[i]  <= '0;
        r_px_y[i]  <= '0;
      end
    end else if (bus.pix_en) begin
      r_flags[0] <= w_s1_flags;
      r_px_x[0]  <= w_s1_x;
      r_px_y[0]  <= w_s1_y;
      for (int i = 1; i <= DLY; i++) begin
        r_flags[i] <= r_flags[i-1];
        r_px_x[i]  <= r_px_x[i-1];
        r_px_y[i]  <= r_px_y[i-1];
      end
    end
  end

  // Completed frames; w_v_wrap already implies a running tick.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + FC_W'(1);
    end
  end

  assign bus.h_count     = w_h_count;
  assign bus.v_count     = w_v_count;
  assign bus.px_x        = r_px_x[DLY];
  assign bus.px_y        = r_px_y[DLY];
  assign bus.video_on    = r_flags[DLY].video_on;
  assign bus.h_sync      = r_flags[DLY].h_sync;
  assign bus.v_sync      = r_flags[DLY].v_sync;
  assign bus.line_start  = r_flags[DLY].line_start;
  assign bus.frame_start = r_flags[DLY].frame_start;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance, a small mode
// with PIPE_DLY=3, and a tiny active-high-hsync mode whose counters fill CW.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(11), .FC_W(8)) def_if ();
  vga_timing_gen_if #(.CW(5),  .FC_W(8)) dly_if ();
  vga_timing_gen_if #(.CW(3),  .FC_W(8)) tiny_if ();

  vga_timing_gen #(.CW(11)) u_def (
    .vga_clk (clk), .rst_n (rst_n), .bus (def_if.master));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CW(5), .PIPE_DLY(3)
  ) u_dly (
    .vga_clk (clk), .rst_n (rst_n), .bus (dly_if.master));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .CW(3)
  ) u_tiny (
    .vga_clk (clk), .rst_n (rst_n), .bus (tiny_if.master));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int cnt, von, hs, vs, first, last, r1, r2, bad, fs_tick, strobe_k, strobe_fs;
  int p, ex, ey;
  logic found;
  logic prev_ls;
  logic [10:0] prev_h, prev_x;

  initial begin
    rst_n = 1'b0;
    def_if.pix_en  = 1'b1; def_if.run  = 1'b1;
    dly_if.pix_en  = 1'b1; dly_if.run  = 1'b0;
    tiny_if.pix_en = 1'b1; tiny_if.run = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_h_count",     int'(def_if.h_count), 0);
    chk("rst_v_count",     int'(def_if.v_count), 0);
    chk("rst_px_x",        int'(def_if.px_x), 0);
    chk("rst_px_y",        int'(def_if.px_y), 0);
    chk("rst_video_on",    int'(def_if.video_on), 0);
    chk("rst_line_start",  int'(def_if.line_start), 0);
    chk("rst_frame_start", int'(def_if.frame_start), 0);
    chk("rst_h_sync",      int'(def_if.h_sync), 1);
    chk("rst_v_sync",      int'(def_if.v_sync), 1);
    chk("rst_frame_cnt",   int'(def_if.frame_cnt), 0);
    chk("rst_tiny_h_sync", int'(tiny_if.h_sync), 0);
    chk("rst_tiny_v_sync", int'(tiny_if.v_sync), 1);

    // First tick after release
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_tick_h_count",     int'(def_if.h_count), 1);
    chk("first_tick_px_x",        int'(def_if.px_x), 0);
    chk("first_tick_frame_start", int'(def_if.frame_start), 1);
    chk("first_tick_line_start",  int'(def_if.line_start), 1);
    chk("first_tick_video_on",    int'(def_if.video_on), 1);

    // One full default line
    cnt = 0; von = 1; hs = 0; first = -1; last = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cnt++;
      if (def_if.line_start) break;
      if (def_if.video_on) von++;
      if (!def_if.h_sync) begin
        hs++;
        if (first < 0) first = int'(def_if.px_x);
        last = int'(def_if.px_x);
      end
    end
    chk("line_period",        cnt, 800);
    chk("line_video_on_ticks", von, 640);
    chk("line_hsync_ticks",   hs, 96);
    chk("line_hsync_first_x", first, 656);
    chk("line_hsync_last_x",  last, 751);
    chk("line2_px_x",         int'(def_if.px_x), 0);
    chk("line2_px_y",         int'(def_if.px_y), 1);
    chk("line2_no_frame_start", int'(def_if.frame_start), 0);

    // pix_en every second clock
    prev_ls = def_if.line_start; prev_h = def_if.h_count; prev_x = def_if.px_x;
    r1 = -1; r2 = -1; bad = 0;
    for (int c = 1; c <= 5000; c++) begin
      def_if.pix_en = (c % 2 == 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!def_if.pix_en) begin
        if (def_if.h_count !== prev_h || def_if.px_x !== prev_x) bad++;
      end
      prev_h = def_if.h_count; prev_x = def_if.px_x;
      if (def_if.line_start && !prev_ls) begin
        if (r1 < 0) r1 = c; else r2 = c;
      end
      prev_ls = def_if.line_start;
      if (r2 >= 0) break;
    end
    def_if.pix_en = 1'b1;
    chk("half_rate_line_period", r2 - r1, 1600);
    chk("half_rate_hold_stable", bad, 0);

    // PIPE_DLY=3 instance, idle since reset
    chk("dly_idle_h_count",  int'(dly_if.h_count), 0);
    chk("dly_idle_h_sync",   int'(dly_if.h_sync), 1);
    chk("dly_idle_video_on", int'(dly_if.video_on), 0);
    dly_if.run = 1'b1;
    fs_tick = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("dly_first_tick_h", int'(dly_if.h_count), 1);
      if (dly_if.frame_start) begin fs_tick = k; break; end
    end
    chk("dly_frame_start_latency", fs_tick, 4);
    chk("dly_fs_h_count", int'(dly_if.h_count), 4);
    chk("dly_fs_px_x",    int'(dly_if.px_x), 0);
    chk("dly_fs_px_y",    int'(dly_if.px_y), 0);

    // One full small-mode frame (24 x 12)
    cnt = 0; von = 1; hs = 0; vs = 0; first = -1; last = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cnt++;
      if (dly_if.frame_start) break;
      if (dly_if.video_on) von++;
      if (!dly_if.h_sync) hs++;
      if (!dly_if.v_sync) begin
        vs++;
        if (first < 0) first = int'(dly_if.px_y);
        last = int'(dly_if.px_y);
      end
    end
    chk("dly_frame_period",    cnt, 288);
    chk("dly_video_on_ticks",  von, 128);
    chk("dly_hsync_ticks",     hs, 48);
    chk("dly_vsync_ticks",     vs, 48);
    chk("dly_vsync_first_y",   first, 9);
    chk("dly_vsync_last_y",    last, 10);
    chk("dly_frame_cnt_1",     int'(dly_if.frame_cnt), 1);

    // Stop mid-frame at h=10, v=5
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dly_if.h_count == 5'd10 && dly_if.v_count == 5'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("dly_reach_h10_v5", int'(found), 1);
    dly_if.run = 1'b0;
    @(negedge clk);
    chk("stop_h_count_zero", int'(dly_if.h_count), 0);
    chk("stop_v_count_zero", int'(dly_if.v_count), 0);
    @(negedge clk);
    @(negedge clk);
    chk("stop_tick3_video_on", int'(dly_if.video_on), 1);
    chk("stop_tick3_px_x",     int'(dly_if.px_x), 9);
    @(negedge clk);
    chk("stop_tick4_video_on",    int'(dly_if.video_on), 0);
    chk("stop_tick4_h_sync",      int'(dly_if.h_sync), 1);
    chk("stop_tick4_v_sync",      int'(dly_if.v_sync), 1);
    chk("stop_tick4_px_x",        int'(dly_if.px_x), 0);
    chk("stop_tick4_frame_start", int'(dly_if.frame_start), 0);
    repeat (5) @(negedge clk);
    chk("stop_frame_cnt_holds", int'(dly_if.frame_cnt), 1);
    chk("stop_h_count_held",    int'(dly_if.h_count), 0);

    // Restart: first strobe is frame_start after 4 ticks
    dly_if.run = 1'b1;
    strobe_k = -1; strobe_fs = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dly_if.line_start || dly_if.frame_start) begin
        strobe_k = k; strobe_fs = int'(dly_if.frame_start); break;
      end
    end
    chk("restart_strobe_latency", strobe_k, 4);
    chk("restart_strobe_is_frame", strobe_fs, 1);

    // Tiny mode: cycle model for two frames, frame_cnt wrap after 256 frames
    tiny_if.run = 1'b1;
    bad = 0;
    for (int t = 1; t <= 48 * 256; t++) begin
      @(negedge clk);
      if (t <= 96) begin
        p = (t - 1) % 48; ex = p % 8; ey = p / 8;
        if (int'(tiny_if.h_count) != t % 8) bad++;
        if (int'(tiny_if.v_count) != (t / 8) % 6) bad++;
        if (int'(tiny_if.px_x) != ex) bad++;
        if (int'(tiny_if.px_y) != ey) bad++;
        if (tiny_if.video_on !== (ex < 4 && ey < 3)) bad++;
        if (tiny_if.h_sync !== (ex >= 5 && ex <= 6)) bad++;
        if (tiny_if.v_sync !== (ey != 4)) bad++;
        if (tiny_if.line_start !== (ex == 0)) bad++;
        if (tiny_if.frame_start !== (ex == 0 && ey == 0)) bad++;
        if (int'(tiny_if.frame_cnt) != (t / 48) % 256) bad++;
      end
      if (t == 6)  chk("tiny_hsync_at_x5", int'(tiny_if.h_sync), 1);
      if (t == 8)  chk("tiny_hsync_at_x7", int'(tiny_if.h_sync), 0);
      if (t == 49) chk("tiny_frame2_start", int'(tiny_if.frame_start), 1);
      if (t == 48 * 255) chk("tiny_frame_cnt_255", int'(tiny_if.frame_cnt), 255);
      if (t == 48 * 256) chk("tiny_frame_cnt_wrap", int'(tiny_if.frame_cnt), 0);
    end
    chk("tiny_model_mismatches", bad, 0);

    // Asynchronous reset mid-line
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_h_count",   int'(def_if.h_count), 0);
    chk("arst_px_x",      int'(def_if.px_x), 0);
    chk("arst_h_sync",    int'(def_if.h_sync), 1);
    chk("arst_video_on",  int'(def_if.video_on), 0);
    chk("arst_dly_frame_cnt", int'(dly_if.frame_cnt), 0);
    chk("arst_tiny_h_sync",   int'(tiny_if.h_sync), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_resume_h_count",     int'(def_if.h_count), 1);
    chk("arst_resume_frame_start", int'(def_if.frame_start), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
